axi_dw_rd_scheduler: RTL

- Shares the AR/R channels of one data-width converter slave port between NumReq read requesters.
- Arbitrates AR requests round-robin and prefixes each issued ID with the requester index.
- Caps outstanding converter reads at MaxReads (matches the converter's AxiMaxReads) and routes R handshakes back by ID prefix.
- AR payload is carried through a register stage; R data/resp/user fan out externally, and this block owns only R valid/ready/id.

---
 rtl/axi_dw_sched_pkg.sv | 18 +
 rtl/axi_dw_rr_pick.sv | 24 ++
 rtl/axi_dw_rd_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/axi_dw_sched_pkg.sv
// Shared types and width helpers for the data-width converter read scheduler.
package axi_dw_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Enough bits to hold the value max_reads itself, not just max_reads-1.
    function automatic int cnt_width(input int max_reads);
        return $clog2(max_reads + 1);
    endfunction

endpackage

// File: rtl/axi_dw_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module axi_dw_rr_pick #(
    parameter int NumReq   = 4,
    parameter int IdxWidth = 2
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [IdxWidth-1:0] winner,
    output logic                any_valid
);

    // Scan from farthest to nearest so the closest request to ptr is written last.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NumReq]) begin
                winner    = IdxWidth'((int'(ptr) + k) % NumReq);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_dw_rd_scheduler.sv
// Shares one converter AR/R port between NumReq requesters: round-robin AR issue,
// in-flight read limiting, and R routing by the requester index carried in the ID.
module axi_dw_rd_scheduler
    import axi_dw_sched_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int MaxReads  = 8,
    parameter int IdWidth   = 4,
    parameter int AddrWidth = 32,
    localparam int IdxWidth = idx_width(NumReq),
    localparam int CntWidth = cnt_width(MaxReads)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_ar_valid_i,
    output logic [NumReq-1:0]             req_ar_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_ar_addr_i,
    input  logic [NumReq*8-1:0]           req_ar_len_i,
    input  logic [NumReq*IdWidth-1:0]     req_ar_id_i,
    output logic                          mst_ar_valid_o,
    input  logic                          mst_ar_ready_i,
    output logic [AddrWidth-1:0]          mst_ar_addr_o,
    output logic [7:0]                    mst_ar_len_o,
    output logic [IdxWidth+IdWidth-1:0]   mst_ar_id_o,
    input  logic                          mst_r_valid_i,
    output logic                          mst_r_ready_o,
    input  logic                          mst_r_last_i,
    input  logic [IdxWidth+IdWidth-1:0]   mst_r_id_i,
    output logic [NumReq-1:0]             req_r_valid_o,
    input  logic [NumReq-1:0]             req_r_ready_i,
    output logic [IdWidth-1:0]            req_r_id_o,
    output logic [CntWidth-1:0]           outstanding_o,
    output logic                          err_o
);

    state_e                        state;
    logic                          ar_valid;
    logic [IdxWidth-1:0]           rr_ptr;
    logic [AddrWidth-1:0]          pay_addr;
    logic [7:0]                    pay_len;
    logic [IdxWidth+IdWidth-1:0]   pay_id;
    logic [CntWidth-1:0]           count;
    logic                          err;

    logic [IdxWidth-1:0]           pick_idx;
    logic                          pick_any;
    logic                          grant;
    logic                          ar_hs;
    logic [IdxWidth-1:0]           held_idx;
    logic [IdxWidth-1:0]           r_idx;
    logic                          r_idx_ok;
    logic                          r_last_hs;

    axi_dw_rr_pick #(
        .NumReq  (NumReq),
        .IdxWidth(IdxWidth)
    ) u_pick (
        .req      (req_ar_valid_i),
        .ptr      (rr_ptr),
        .winner   (pick_idx),
        .any_valid(pick_any)
    );

    // Only the registered count gates a grant, so a same-cycle R-last cannot unblock it.
    assign grant    = (state == IDLE) && (count < CntWidth'(MaxReads)) && pick_any;
    assign ar_hs    = ar_valid && mst_ar_ready_i;
    assign held_idx = pay_id[IdxWidth+IdWidth-1:IdWidth];

    always_comb begin
        req_ar_ready_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_ar_ready_o[i] = grant && (pick_idx == IdxWidth'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            ar_valid <= 1'b0;
            rr_ptr   <= '0;
            pay_addr <= '0;
            pay_len  <= '0;
            pay_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        pay_addr <= req_ar_addr_i[pick_idx*AddrWidth +: AddrWidth];
                        pay_len  <= req_ar_len_i[pick_idx*8 +: 8];
                        pay_id   <= {pick_idx, req_ar_id_i[pick_idx*IdWidth +: IdWidth]};
                        state    <= ISSUE;
                        ar_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mst_ar_ready_i) begin
                        state    <= IDLE;
                        ar_valid <= 1'b0;
                        rr_ptr   <= (32'(held_idx) == NumReq - 1) ? '0 : held_idx + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ar_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mst_ar_valid_o = ar_valid;
    assign mst_ar_addr_o  = pay_addr;
    assign mst_ar_len_o   = pay_len;
    assign mst_ar_id_o    = pay_id;

    // Indices beyond NumReq (non-power-of-two NumReq) are swallowed so the converter never stalls.
    assign r_idx    = mst_r_id_i[IdxWidth+IdWidth-1:IdWidth];
    assign r_idx_ok = 32'(r_idx) < NumReq;

    always_comb begin
        req_r_valid_o = '0;
        mst_r_ready_o = 1'b1;
        for (int i = 0; i < NumReq; i++) begin
            if (r_idx_ok && (r_idx == IdxWidth'(i))) begin
                req_r_valid_o[i] = mst_r_valid_i;
                mst_r_ready_o    = req_r_ready_i[i];
            end
        end
    end

    assign req_r_id_o = mst_r_id_i[IdWidth-1:0];
    assign r_last_hs  = mst_r_valid_i && mst_r_ready_o && mst_r_last_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (ar_hs && !r_last_hs) begin
                count <= count + 1'b1;
            end else if (!ar_hs && r_last_hs && (count != '0)) begin
                count <= count - 1'b1;
            end
            if ((r_last_hs && (count == '0)) || (mst_r_valid_i && !r_idx_ok)) begin
                err <= 1'b1;
            end
        end
    end

    assign outstanding_o = count;
    assign err_o         = err;

endmodule
